// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR_L = 3'd1,
        S_HDR_H = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    localparam int         CNT_W         = 16;
    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/byte_packer.sv
// Packs payload bytes into little-endian words and keeps a running mod-256 sum.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  sum
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] data_q, data_d;
    logic [7:0]  sum_q, sum_d;

    always_comb begin
        lane_d     = lane_q;
        data_d     = data_q;
        sum_d      = sum_q;
        word_valid = in_valid && (lane_q == 2'd3);
        word       = {in_data, data_q};
        sum        = sum_q;
        if (clear) begin
            lane_d = '0;
            data_d = '0;
            sum_d  = '0;
        end else if (in_valid) begin
            sum_d  = sum_q + in_data;
            lane_d = lane_q + 2'd1;
            // lane 3 is consumed directly from in_data when the word is emitted
            if (lane_q != 2'd3)
                data_d[{lane_q, 3'b000} +: 8] = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            data_q <= '0;
            sum_q  <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory writes, gates CPU reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = 14,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_ena,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IW = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ena_q, ena_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dina_q, dina_d;
    logic              rdy_q, rdy_d;
    logic              crst_q, crst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic             accept;
    logic             pk_clear;
    logic             pk_valid;
    logic             word_valid;
    logic [31:0]      word;
    logic [7:0]       sum;
    logic [CNT_W-1:0] n_new;

    assign accept   = rx_valid && rdy_q;
    assign pk_valid = accept && (state_q == S_DATA);
    assign n_new    = {rx_data, n_q[7:0]};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .in_valid   (pk_valid),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word       (word),
        .sum        (sum)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        ena_d    = 1'b0;
        addr_d   = '0;
        dina_d   = '0;
        pk_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == MAGIC)
                    state_d = S_HDR_L;
            end
            S_HDR_L: begin
                if (accept) begin
                    n_d[7:0] = rx_data;
                    state_d  = S_HDR_H;
                end
            end
            S_HDR_H: begin
                if (accept) begin
                    n_d[15:8] = rx_data;
                    idx_d     = '0;
                    pk_clear  = 1'b1;
                    if (32'(n_new) > (32'd1 << ADDR_W))
                        state_d = S_ERR;
                    else if (n_new == '0)
                        state_d = S_CSUM;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && word_valid) begin
                    ena_d  = 1'b1;
                    addr_d = idx_q[ADDR_W-1:0];
                    dina_d = word;
                    idx_d  = idx_q + 1'b1;
                    if (32'(idx_q) + 32'd1 == 32'(n_q))
                        state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (rx_data == sum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (reload)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d  = (state_d != S_DONE) && (state_d != S_ERR);
        busy_d = rdy_d && (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        crst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            ena_q   <= 1'b0;
            addr_q  <= '0;
            dina_q  <= '0;
            rdy_q   <= 1'b0;
            crst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
            dina_q  <= dina_d;
            rdy_q   <= rdy_d;
            crst_q  <= crst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_ready   = rdy_q;
    assign imem_ena   = ena_q;
    assign imem_wea   = {4{ena_q}};
    assign imem_addra = addr_q;
    assign imem_dina  = dina_q;
    assign cpu_reset  = crst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          reload = 1'b0;
    logic          imem_ena;
    logic [3:0]    imem_wea;
    logic [AW-1:0] imem_addra;
    logic [31:0]   imem_dina;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  nwr = 0;
    int  w0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && imem_ena === 1'b1) begin : mon
            wr_t e;
            nwr++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%h expected none",
                       imem_addra);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addra), 32'(e.a));
                chk("wr_data", imem_dina, e.d);
                chk("wr_wea", 32'(imem_wea), 32'hF);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] words[$], input logic [7:0] delta,
                              input int maxgap);
        logic [7:0]  s = '0;
        logic [7:0]  b;
        logic [15:0] n;
        n = 16'(words.size());
        send(8'hA5, 0);
        send(n[7:0], 0);
        send(n[15:8], 0);
        for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back({AW'(i), words[i]});
            for (int k = 0; k < 4; k++) begin
                b = words[i][8*k +: 8];
                s = s + b;
                send(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            end
        end
        send(s + delta, 0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({p, "_ena"}, 32'(imem_ena), 32'd0);
        chk({p, "_wea"}, 32'(imem_wea), 32'd0);
        chk({p, "_addra"}, 32'(imem_addra), 32'd0);
        chk({p, "_dina"}, imem_dina, 32'd0);
        chk({p, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_done"}, 32'(done), 32'd0);
        chk({p, "_err"}, 32'(err), 32'd0);
    endtask

    logic [31:0] wq[$];

    initial begin
        #3 reset = 1'b0;
        #4;
        chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rel_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_rel_cpu_reset", 32'(cpu_reset), 32'd1);

        // good two-word frame
        w0 = nwr;
        wq = '{32'h00000013, 32'h00100093};
        send_frame(wq, 8'd0, 0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t1_rx_ready", 32'(rx_ready), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_nwr", 32'(nwr - w0), 32'd2);
        pulse_reload();
        chk("t1_rl_done", 32'(done), 32'd0);
        chk("t1_rl_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t1_rl_rx_ready", 32'(rx_ready), 32'd1);

        // bad checksum
        w0 = nwr;
        send_frame(wq, 8'd1, 0);
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t2_rx_ready", 32'(rx_ready), 32'd0);
        chk("t2_nwr", 32'(nwr - w0), 32'd2);
        pulse_reload();
        chk("t2_rl_err", 32'(err), 32'd0);
        chk("t2_rl_rx_ready", 32'(rx_ready), 32'd1);

        // junk bytes then empty frame
        w0 = nwr;
        send(8'h00, 0);
        send(8'hFF, 0);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        send(8'hA5, 0);
        chk("t3_hdr_busy", 32'(busy), 32'd1);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("t3_csum_busy", 32'(busy), 32'd1);
        send(8'h00, 0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_nwr", 32'(nwr - w0), 32'd0);
        pulse_reload();

        // count one above capacity
        w0 = nwr;
        send(8'hA5, 0);
        send(8'h11, 0);
        send(8'h00, 0);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rx_ready", 32'(rx_ready), 32'd0);
        chk("t4_nwr", 32'(nwr - w0), 32'd0);
        pulse_reload();

        // full capacity, addresses 0..15
        w0 = nwr;
        wq = {};
        for (int i = 0; i < 16; i++) wq.push_back($urandom);
        send_frame(wq, 8'd0, 0);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_nwr", 32'(nwr - w0), 32'd16);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        pulse_reload();

        // random valid gaps
        w0 = nwr;
        wq = {};
        for (int i = 0; i < 5; i++) wq.push_back($urandom);
        send_frame(wq, 8'd0, 3);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_nwr", 32'(nwr - w0), 32'd5);
        pulse_reload();

        // async reset mid-DATA, then a clean frame
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        chk("t7_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("t7_async");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        w0 = nwr;
        wq = '{32'h00000013, 32'h00100093};
        send_frame(wq, 8'd0, 0);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t7_nwr", 32'(nwr - w0), 32'd2);
        chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
